// File: rtl/fp_addsub_pkg.sv
// Shared types and defaults for the floating-point add/subtract pipeline.
// Holds the operand field widths, the aligned-mantissa width and the operand classes.
package fp_addsub_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  // Aligned mantissa: hidden bit, fraction, then guard/round/sticky.
  function automatic int unsigned aligned_width(input int unsigned man_w);
    return man_w + 4;
  endfunction

  localparam int unsigned AW_DEF = aligned_width(MAN_W_DEF);

  typedef struct packed {
    logic                 sign;
    logic [EXP_W_DEF-1:0] exp_eff;
    logic [AW_DEF-1:0]    mant;
  } fp_unpacked_t;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_DENORM,
    CLS_ZERO,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

endpackage

// File: rtl/fpaddsub_align_shift.sv
// Right barrel shifter with sticky collapse into bit 0.
// Any one bit shifted out sets the sticky bit.
module fpaddsub_align_shift #(
  parameter int unsigned AW = 27,
  parameter int unsigned SW = 8
) (
  input  logic [AW-1:0] i_mant,
  input  logic [SW-1:0] i_shamt,
  output logic [AW-1:0] o_mant
);

  logic [AW-1:0] w_shifted;
  logic [AW-1:0] w_mask;
  logic          w_lost;

  always_comb begin
    w_shifted = i_mant >> i_shamt;
    w_mask    = ~({AW{1'b1}} << i_shamt);
    w_lost    = |(i_mant & w_mask);
    if (32'(i_shamt) >= AW) begin
      o_mant = {{(AW-1){1'b0}}, |i_mant};
    end else begin
      o_mant = {w_shifted[AW-1:1], w_shifted[0] | w_lost};
    end
  end

endmodule

// File: rtl/fpaddsub_prealign_pipe.sv
// Two-stage pre-alignment front end: unpack, classify, order by magnitude, then align
// the smaller mantissa with sticky. Valid/ready flow control on both sides.
module fpaddsub_prealign_pipe
  import fp_addsub_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [EXP_W+MAN_W:0]        i_a,
  input  logic [EXP_W+MAN_W:0]        i_b,
  input  logic                        i_op,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic                        o_s_large,
  output logic                        o_eff_sub,
  output logic                        o_swap,
  output logic [EXP_W-1:0]            o_e_large,
  output logic [MAN_W+3:0]            o_m_large,
  output logic [MAN_W+3:0]            o_m_small,
  output logic                        o_is_nan,
  output logic                        o_is_inf,
  output logic                        o_is_zero
);

  localparam int unsigned AW = aligned_width(MAN_W);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (&e) return (f != '0) ? CLS_NAN : CLS_INF;
    if (e == '0) return (f == '0) ? CLS_ZERO : CLS_DENORM;
    return CLS_NORM;
  endfunction

  logic [EXP_W-1:0] w_a_exp, w_b_exp, w_a_eexp, w_b_eexp, w_e_small, w_d;
  logic [MAN_W-1:0] w_a_frac, w_b_frac;
  logic [AW-1:0]    w_a_mant, w_b_mant, w_m_aligned;
  logic             w_swap, w_eff_sub, w_nan, w_inf, w_zero, w_ld1, w_ld2;
  fp_class_e        w_a_cls, w_b_cls;

  logic             r_v1, r_s_large1, r_eff_sub1, r_swap1, r_nan1, r_inf1, r_zero1;
  logic [EXP_W-1:0] r_e_large1, r_d1;
  logic [AW-1:0]    r_m_large1, r_m_small1;
  logic             r_v2;

  always_comb begin
    w_a_exp   = i_a[MAN_W +: EXP_W];
    w_b_exp   = i_b[MAN_W +: EXP_W];
    w_a_frac  = i_a[MAN_W-1:0];
    w_b_frac  = i_b[MAN_W-1:0];
    w_a_cls   = classify(w_a_exp, w_a_frac);
    w_b_cls   = classify(w_b_exp, w_b_frac);
    // Zero/denormal operands use effective exponent 1 with hidden bit 0.
    w_a_eexp  = (w_a_exp == '0) ? EXP_W'(1) : w_a_exp;
    w_b_eexp  = (w_b_exp == '0) ? EXP_W'(1) : w_b_exp;
    w_a_mant  = {(w_a_exp != '0), w_a_frac, 3'b000};
    w_b_mant  = {(w_b_exp != '0), w_b_frac, 3'b000};
    w_swap    = {w_b_exp, w_b_frac} > {w_a_exp, w_a_frac};
    w_e_small = w_swap ? w_a_eexp : w_b_eexp;
    w_d       = (w_swap ? w_b_eexp : w_a_eexp) - w_e_small;
    w_eff_sub = i_a[EXP_W+MAN_W] ^ i_b[EXP_W+MAN_W] ^ i_op;
    w_nan     = (w_a_cls == CLS_NAN) || (w_b_cls == CLS_NAN) ||
                ((w_a_cls == CLS_INF) && (w_b_cls == CLS_INF) && w_eff_sub);
    w_inf     = !w_nan && ((w_a_cls == CLS_INF) || (w_b_cls == CLS_INF));
    w_zero    = (w_a_cls == CLS_ZERO) && (w_b_cls == CLS_ZERO);
    w_ld2     = r_v1 && (!r_v2 || i_out_ready);
    w_ld1     = !r_v1 || w_ld2;
  end

  assign o_in_ready  = w_ld1;
  assign o_out_valid = r_v2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v1       <= 1'b0;
      r_s_large1 <= 1'b0;
      r_eff_sub1 <= 1'b0;
      r_swap1    <= 1'b0;
      r_nan1     <= 1'b0;
      r_inf1     <= 1'b0;
      r_zero1    <= 1'b0;
      r_e_large1 <= '0;
      r_d1       <= '0;
      r_m_large1 <= '0;
      r_m_small1 <= '0;
    end else if (w_ld1) begin
      r_v1 <= i_in_valid;
      if (i_in_valid) begin
        r_s_large1 <= w_swap ? (i_b[EXP_W+MAN_W] ^ i_op) : i_a[EXP_W+MAN_W];
        r_eff_sub1 <= w_eff_sub;
        r_swap1    <= w_swap;
        r_nan1     <= w_nan;
        r_inf1     <= w_inf;
        r_zero1    <= w_zero;
        r_e_large1 <= w_swap ? w_b_eexp : w_a_eexp;
        r_d1       <= w_d;
        r_m_large1 <= w_swap ? w_b_mant : w_a_mant;
        r_m_small1 <= w_swap ? w_a_mant : w_b_mant;
      end
    end
  end

  fpaddsub_align_shift #(
    .AW (AW),
    .SW (EXP_W)
  ) u_align_shift (
    .i_mant  (r_m_small1),
    .i_shamt (r_d1),
    .o_mant  (w_m_aligned)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_v2        <= 1'b0;
      o_s_large   <= 1'b0;
      o_eff_sub   <= 1'b0;
      o_swap      <= 1'b0;
      o_e_large   <= '0;
      o_m_large   <= '0;
      o_m_small   <= '0;
      o_is_nan    <= 1'b0;
      o_is_inf    <= 1'b0;
      o_is_zero   <= 1'b0;
    end else if (w_ld2) begin
      r_v2        <= 1'b1;
      o_s_large   <= r_s_large1;
      o_eff_sub   <= r_eff_sub1;
      o_swap      <= r_swap1;
      o_e_large   <= r_e_large1;
      o_m_large   <= r_m_large1;
      o_m_small   <= w_m_aligned;
      o_is_nan    <= r_nan1;
      o_is_inf    <= r_inf1;
      o_is_zero   <= r_zero1 && !r_nan1 && !r_inf1;
    end else if (i_out_ready) begin
      r_v2 <= 1'b0;
    end
  end

endmodule

// File: doc/fpaddsub_prealign_pipe.md
# fpaddsub_prealign_pipe

Parametrised, two-stage pipelined front end for the floating-point adder/subtractor. It unpacks two IEEE-754-style operands and classifies specials. It orders the operands by magnitude and right-aligns the smaller mantissa with guard/round/sticky bits. Sits between the operand source and the mantissa add/normalise stages, with valid/ready flow control on both sides.

## Interface
Parameters:
- EXP_W, 8, exponent field width
- MAN_W, 23, stored fraction width; aligned width AW = MAN_W+4 (hidden, fraction, G, R, S)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- a, b  in  1+EXP_W+MAN_W each  operands {sign, exp, frac}
- op  in  1  0 = add, 1 = subtract
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- s_large  out  1  sign of larger-magnitude operand (after op applied if it is b)
- eff_sub  out  1  a.sign ^ b.sign ^ op
- swap  out  1  b had larger magnitude
- e_large  out  EXP_W  effective exponent of larger operand
- m_large  out  AW  larger mantissa, hidden bit at AW-1, G/R/S zero
- m_small  out  AW  aligned smaller mantissa, bit 0 = sticky
- is_nan, is_inf, is_zero  out  1 each  special-case flags for the result

## Operation
- Unpack: exp == 0 gives hidden bit 0 and effective exponent 1 (denormal/zero). Otherwise hidden bit 1 and effective exponent exp.
- Mantissa in AW field: {hidden, frac, 3'b000}.
- Magnitude compare on {exp, frac}. swap = 1 iff b strictly greater. On tie, a is large and swap = 0.
- s_large = swap ? b.sign ^ op : a.sign.
- d = e_large_eff − e_small_eff, unsigned, at most 2^EXP_W − 2.
- m_small = small mantissa >> d. Bit 0 = OR of all bits shifted out OR the bit landing in position 0.
- If d ≥ AW: m_small = {AW−1 zeros, OR(small mantissa)}.
- Specials (exp all ones):
  - is_nan: either operand NaN, or both infinite with eff_sub = 1.
  - is_inf: otherwise, either operand infinite.
  - is_zero: both operands zero and not nan/inf.
  - Flags do not alter the datapath outputs.
- Stage 1 registers: unpack, compare, swap, d, flags.
- Stage 2 registers: barrel shift, sticky.

## Timing
- Latency: 2 cycles from accepted input (in_valid && in_ready) to out_valid.
- Full throughput is one pair per cycle.
- ld2 = v1 && (!v2 || out_ready). Stage 1 loads when !v1 || ld2. in_ready = !v1 || ld2 (combinational from out_ready).
- While out_valid && !out_ready, all outputs are held stable.
- The same-cycle accept-and-drain in both stages keeps the pipe full with no bubble.
- Reset (rst_n low at clk edge):
  - Both valid bits and all outputs go to 0; in_ready = 1 in the following cycle.
  - Reset mid-operation discards in-flight pairs. No partial output appears.
- Inputs are sampled only on accept. a/b/op may change freely otherwise.

## Structure
- Shared package fp_addsub_pkg holds:
  - EXP_W/MAN_W defaults and AW derivation.
  - Unpacked-operand struct {sign, exp_eff, mant}.
  - Special-class enum {NORM, DENORM, ZERO, INF, NAN}.
- One sub-module is natural: fpaddsub_align_shift (parametrised right barrel shifter with sticky, combinational, used in stage 2).

## Test plan
- a=0x3F800000, b=0x3F800000, op=0 -> swap=0, e_large=127, m_large=m_small=0x4000000, eff_sub=0, latency 2.
- a=0x40000000, b=0x3FA00000 -> d=1, m_large=0x4000000, m_small=0x2800000, sticky 0.
- a=0x40220000, b=0x44000000, op=1 -> swap=1, e_large=136, m_small=0x0051000, s_large=1, eff_sub=1.
- a=0x63E00000, b=0x00800040 -> d=198, m_small=0x0000001. Also a=0x41000000, b=0 -> m_small=0, is_zero=0.
- a=0x7F800000, b=0x7F800000, op=1 -> is_nan=1. a=0x7F800000, b=0x3F800000 -> is_inf=1, is_nan=0.
- Back-to-back stream of 8 pairs with out_ready toggling 1/0 each cycle -> every result in order, none dropped or duplicated, outputs stable while stalled. rst_n low with 2 pairs in flight -> out_valid=0 next cycle, no stale outputs after.
